// File: rtl/overlap_window_address_manager_pkg.sv
// -----------------------------------------------------------------------------
// overlap_window_address_manager_pkg
//
// Shared definitions for the overlapped-window address manager:
//   - pow2()      : size of a power-of-two region from its address width
//   - clamp_hop() : maps a raw hop request onto the legal range 1..WIN
//
// A hop of zero, or one larger than the window, would break the invariant
// win_start <= deq_ptr.  Both cases are treated as "no overlap" (hop = WIN).
// -----------------------------------------------------------------------------
package overlap_window_address_manager_pkg;

  // Number of entries addressed by a field of the given width.
  function automatic int unsigned pow2(input int unsigned width);
    return 32'd1 << width;
  endfunction

  // Effective hop for a window of 'win' samples.
  function automatic int unsigned clamp_hop(input int unsigned hop,
                                            input int unsigned win);
    if (hop == 0 || hop > win) begin
      return win;
    end
    return hop;
  endfunction

endpackage : overlap_window_address_manager_pkg

// File: rtl/overlap_window_address_manager_pipe_delay.sv
// -----------------------------------------------------------------------------
// pipe_delay
//
// Fixed-length register pipeline.  STAGES = 0 degenerates to a wire.
//
// Parameters:
//   WIDTH  - data width in bits
//   STAGES - number of register stages (>= 0)
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset, clears every stage
//   data_i - pipeline input
//   data_o - data_i delayed by STAGES cycles
// -----------------------------------------------------------------------------
module pipe_delay #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (STAGES == 0) begin : g_pass
    assign data_o = data_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: every stage is reset, not just the valid bit; a reset in the
    // middle of a window must not let stale tags leak out afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < STAGES; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q[0] <= data_i;
        for (int i = 1; i < STAGES; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign data_o = stage_q[STAGES-1];
  end

endmodule : pipe_delay

// File: rtl/overlap_window_address_manager.sv
// -----------------------------------------------------------------------------
// overlap_window_address_manager
//
// Address generator and occupancy tracker for the circular sample buffer that
// feeds overlapped analysis windows to the FFT.  Samples are written in order;
// reads walk a window of WIN samples starting at win_start.  When a window
// completes, win_start advances by the hop and reading restarts there, so
// WIN - hop samples are re-read by the next window.  The hop is sampled once
// per window (on its first read) and may change between windows.
//
// Parameters:
//   WINWIDTH   - log2 of window length WIN
//   ADDRWIDTH  - log2 of buffer depth DEPTH (must be >= WINWIDTH)
//   RD_LATENCY - RAM read latency applied to the rd_* outputs
//   HOP_RESET  - hop used for the window in progress after reset
//
// Ports:
//   clock, reset_n       - clock, asynchronous active-low reset
//   enqueue / dequeue    - write / read requests
//   hop                  - requested hop in samples (0 or > WIN means WIN)
//   full / empty / level - occupancy (level = samples still retained)
//   write_addr/read_addr - RAM addresses
//   write / read         - accepted write / read this cycle
//   window_addr          - sample index inside the current window
//   first / last         - read is sample 0 / WIN-1 of its window
//   rd_valid, rd_window_addr, rd_last - read tags aligned to RAM data
// -----------------------------------------------------------------------------
module overlap_window_address_manager
  import overlap_window_address_manager_pkg::*;
#(
  parameter int WINWIDTH   = 10,
  parameter int ADDRWIDTH  = 12,
  parameter int RD_LATENCY = 1,
  parameter int HOP_RESET  = 2 ** (WINWIDTH - 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enqueue,
  input  logic                 dequeue,
  input  logic [WINWIDTH:0]    hop,
  output logic                 full,
  output logic                 empty,
  output logic [ADDRWIDTH:0]   level,
  output logic [ADDRWIDTH-1:0] write_addr,
  output logic [ADDRWIDTH-1:0] read_addr,
  output logic                 write,
  output logic                 read,
  output logic [WINWIDTH-1:0]  window_addr,
  output logic                 first,
  output logic                 last,
  output logic                 rd_valid,
  output logic [WINWIDTH-1:0]  rd_window_addr,
  output logic                 rd_last
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int unsigned WIN   = pow2(WINWIDTH);
  localparam int unsigned DEPTH = pow2(ADDRWIDTH);
  localparam int          PW    = ADDRWIDTH + 1;  // pointer width (wrap bit)
  localparam int          HW    = WINWIDTH + 1;   // hop width (holds WIN)
  localparam int          TW    = WINWIDTH + 2;   // read tag width

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  if (ADDRWIDTH < WINWIDTH) begin : g_bad_cfg
    $error("overlap_window_address_manager: ADDRWIDTH must be >= WINWIDTH");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Pointers carry one extra bit so that a buffer holding exactly DEPTH
  // samples is distinguishable from an empty one.
  logic [PW-1:0]       enq_ptr_q,   enq_ptr_d;
  logic [PW-1:0]       deq_ptr_q,   deq_ptr_d;
  logic [PW-1:0]       win_start_q, win_start_d;
  logic [WINWIDTH-1:0] win_cnt_q,   win_cnt_d;
  logic [HW-1:0]       hop_lat_q,   hop_lat_d;

  // ---------------------------------------------------------------------------
  // Combinational status and handshakes (all from current registers)
  // ---------------------------------------------------------------------------
  logic [HW-1:0] hop_eff;
  logic [HW-1:0] hop_used;
  logic [PW-1:0] next_start;

  assign hop_eff = HW'(clamp_hop(32'(hop), WIN));

  // Space is only reclaimed when a window completes, so occupancy is measured
  // from win_start rather than from the read pointer.
  assign level = enq_ptr_q - win_start_q;
  assign full  = (level == DEPTH_P);
  assign empty = (deq_ptr_q == enq_ptr_q);

  assign write = enqueue & ~full;
  assign read  = dequeue & ~empty;
  assign first = read & (win_cnt_q == '0);
  assign last  = read & (win_cnt_q == '1);

  // With a one-sample window the first read is also the last, and the hop
  // register has not been loaded yet, so the live hop is used directly.
  assign hop_used   = first ? hop_eff : hop_lat_q;
  assign next_start = win_start_q + PW'(hop_used);

  assign write_addr  = enq_ptr_q[ADDRWIDTH-1:0];
  assign read_addr   = deq_ptr_q[ADDRWIDTH-1:0];
  assign window_addr = win_cnt_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    enq_ptr_d   = enq_ptr_q;
    deq_ptr_d   = deq_ptr_q;
    win_start_d = win_start_q;
    win_cnt_d   = win_cnt_q;
    hop_lat_d   = hop_lat_q;

    if (write) begin
      enq_ptr_d = enq_ptr_q + PW'(1);
    end

    if (read) begin
      deq_ptr_d = deq_ptr_q + PW'(1);
      win_cnt_d = win_cnt_q + WINWIDTH'(1);

      if (first) begin
        hop_lat_d = hop_eff;
      end

      // End of window: rewind the read pointer to the start of the next
      // window, which overlaps the one just finished by WIN - hop samples.
      if (last) begin
        win_cnt_d   = '0;
        win_start_d = next_start;
        deq_ptr_d   = next_start;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr_q   <= '0;
      deq_ptr_q   <= '0;
      win_start_q <= '0;
      win_cnt_q   <= '0;
      hop_lat_q   <= HW'(HOP_RESET);
    end else begin
      enq_ptr_q   <= enq_ptr_d;
      deq_ptr_q   <= deq_ptr_d;
      win_start_q <= win_start_d;
      win_cnt_q   <= win_cnt_d;
      hop_lat_q   <= hop_lat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read tags delayed to line up with RAM read data
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tag_in;
  logic [TW-1:0] tag_out;

  assign tag_in = {read, window_addr, last};

  pipe_delay #(
    .WIDTH  (TW),
    .STAGES (RD_LATENCY)
  ) u_rd_delay (
    .clk    (clock),
    .rst_n  (reset_n),
    .data_i (tag_in),
    .data_o (tag_out)
  );

  assign rd_valid       = tag_out[TW-1];
  assign rd_window_addr = tag_out[TW-2:1];
  assign rd_last        = tag_out[0];

endmodule : overlap_window_address_manager

// File: tb/tb_overlap_window_address_manager.sv
// -----------------------------------------------------------------------------
// tb_overlap_window_address_manager
//
// Bench for WINWIDTH=3 (WIN=8), ADDRWIDTH=4 (DEPTH=16), RD_LATENCY=2.
// The reference model tracks samples by absolute index: total samples
// written, absolute start of the current window, position inside it and the
// hop in force.  RAM addresses are those indices modulo DEPTH.  Read tags
// are modelled with a queue pre-loaded with RD_LATENCY idle entries.
// -----------------------------------------------------------------------------
module tb_overlap_window_address_manager;

  localparam int WINWIDTH   = 3;
  localparam int ADDRWIDTH  = 4;
  localparam int RD_LATENCY = 2;
  localparam int WIN        = 8;
  localparam int DEPTH      = 16;
  localparam int HOP_RST    = 4;

  logic       clock;
  logic       reset_n;
  logic       enqueue;
  logic       dequeue;
  logic [3:0] hop;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic [3:0] write_addr;
  logic [3:0] read_addr;
  logic       write;
  logic       read;
  logic [2:0] window_addr;
  logic       first;
  logic       last;
  logic       rd_valid;
  logic [2:0] rd_window_addr;
  logic       rd_last;

  overlap_window_address_manager #(
    .WINWIDTH   (WINWIDTH),
    .ADDRWIDTH  (ADDRWIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enqueue        (enqueue),
    .dequeue        (dequeue),
    .hop            (hop),
    .full           (full),
    .empty          (empty),
    .level          (level),
    .write_addr     (write_addr),
    .read_addr      (read_addr),
    .write          (write),
    .read           (read),
    .window_addr    (window_addr),
    .first          (first),
    .last           (last),
    .rd_valid       (rd_valid),
    .rd_window_addr (rd_window_addr),
    .rd_last        (rd_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Counters and reference model
  // ---------------------------------------------------------------------------
  int n_cmp;
  int n_err;

  int m_written;   // samples written since reset
  int m_win_base;  // absolute index of current window's sample 0
  int m_pos;       // position inside current window
  int m_hop;       // hop in force for current window

  logic [4:0] m_tags[$];  // {read, window index, last}, oldest first

  logic       cur_write;
  logic       cur_read;
  logic       cur_last;
  logic [3:0] cur_hop;

  function automatic int ref_hop(input int h);
    return (h == 0 || h > WIN) ? WIN : h;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_written  = 0;
    m_win_base = 0;
    m_pos      = 0;
    m_hop      = HOP_RST;
    m_tags     = '{5'd0, 5'd0};
  endtask

  // Apply inputs for one cycle and compare every output with the model.
  task automatic drive(input logic e, input logic d, input logic [3:0] h);
    int         retained;
    int         next_read;
    logic       exp_full;
    logic       exp_empty;
    logic [4:0] old_tag;
    enqueue = e;
    dequeue = d;
    hop     = h;
    #1;
    retained  = m_written - m_win_base;
    next_read = m_win_base + m_pos;
    exp_full  = (retained == DEPTH);
    exp_empty = (next_read == m_written);
    cur_write = e && !exp_full;
    cur_read  = d && !exp_empty;
    cur_last  = cur_read && (m_pos == WIN - 1);
    cur_hop   = h;
    old_tag   = m_tags[0];
    check("full",        32'(full),        32'(exp_full));
    check("empty",       32'(empty),       32'(exp_empty));
    check("level",       32'(level),       retained);
    check("write_addr",  32'(write_addr),  m_written % DEPTH);
    check("read_addr",   32'(read_addr),   next_read % DEPTH);
    check("write",       32'(write),       32'(cur_write));
    check("read",        32'(read),        32'(cur_read));
    check("window_addr", 32'(window_addr), m_pos);
    check("first",       32'(first),       32'(cur_read && m_pos == 0));
    check("last",        32'(last),        32'(cur_last));
    check("rd_valid",    32'(rd_valid),    32'(old_tag[4]));
    check("rd_win_addr", 32'(rd_window_addr), 32'(old_tag[3:1]));
    check("rd_last",     32'(rd_last),     32'(old_tag[0]));
  endtask

  // Clock edge: the model absorbs the transaction decided in drive().
  task automatic advance();
    @(posedge clock);
    m_tags.push_back({cur_read, 3'(m_pos), cur_last});
    void'(m_tags.pop_front());
    if (cur_write) m_written++;
    if (cur_read) begin
      if (m_pos == 0) m_hop = ref_hop(int'(cur_hop));
      if (m_pos == WIN - 1) begin
        m_win_base += m_hop;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    #1;
  endtask

  task automatic step(input logic e, input logic d, input logic [3:0] h);
    drive(e, d, h);
    advance();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    enqueue = 1'b0;
    dequeue = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_full",        32'(full),           0);
    check("rst_empty",       32'(empty),          1);
    check("rst_level",       32'(level),          0);
    check("rst_write_addr",  32'(write_addr),     0);
    check("rst_read_addr",   32'(read_addr),      0);
    check("rst_write",       32'(write),          0);
    check("rst_read",        32'(read),           0);
    check("rst_window_addr", 32'(window_addr),    0);
    check("rst_first",       32'(first),          0);
    check("rst_last",        32'(last),           0);
    check("rst_rd_valid",    32'(rd_valid),       0);
    check("rst_rd_win_addr", 32'(rd_window_addr), 0);
    check("rst_rd_last",     32'(rd_last),        0);
    model_reset();
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence followed by randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset_n   = 1'b1;
    enqueue   = 1'b0;
    dequeue   = 1'b0;
    hop       = 4'd4;
    cur_write = 1'b0;
    cur_read  = 1'b0;
    cur_last  = 1'b0;
    cur_hop   = 4'd4;
    model_reset();
    #2;
    do_reset();

    // 17 writes into a 16-deep buffer: the last one is refused.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 4'd4);
      if (i == 16) check("fill_17th_write", 32'(write), 0);
      advance();
    end
    drive(1'b0, 1'b0, 4'd4);
    check("fill_level", 32'(level), 16);
    check("fill_full",  32'(full),  1);
    advance();

    // hop=4 with dequeue held: windows 0..7, 4..11, 8..15, then part of 12..
    for (int i = 0; i < 26; i++) begin
      drive(1'b0, 1'b1, 4'd4);
      if (i == 8)  check("hop4_w2_start", 32'(read_addr), 4);
      if (i == 16) check("hop4_w3_start", 32'(read_addr), 8);
      advance();
    end

    // Reset with a partial window and read tags in flight.
    do_reset();

    // hop=0 and hop=12 both behave as hop=8 (no overlap).
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, (i < 8) ? 4'd0 : 4'd12);
      if (i == 8) check("nohop_w2_start", 32'(read_addr), 8);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'd4);
      check("nohop_drained", 32'(empty), 1);
      advance();
    end

    // hop changed mid-window: sampled only at each window's first read.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'd4);
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, 1'b1, (i < 3) ? 4'd4 : 4'd2);
      if (i == 8)  check("hopchg_w2_start", 32'(read_addr), 4);
      if (i == 16) check("hopchg_w3_start", 32'(read_addr), 6);
      advance();
    end

    // Last read and enqueue together while full.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'd4);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'd4);
    drive(1'b1, 1'b1, 4'd4);
    check("full_last_write", 32'(write), 0);
    check("full_last_last",  32'(last),  1);
    advance();
    drive(1'b1, 1'b0, 4'd4);
    check("freed_write",      32'(write),      1);
    check("freed_write_addr", 32'(write_addr), 0);
    check("freed_full",       32'(full),       0);
    advance();

    // Randomized traffic with random hops and one reset in the middle.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      step(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_overlap_window_address_manager
